// File: rtl/perm_ctrl_pkg.sv
// perm_ctrl_pkg: shared FSM state encoding and default sizing for perm_ctrl.
`default_nettype none

package perm_ctrl_pkg;

    localparam int DEF_ROUNDS = 24;
    localparam int DEF_ADDR_W = 6;
    localparam int ROUND_W    = 5;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/perm_ctrl_if.sv
// perm_ctrl_if: job request and permutation-memory strobe bundle.
// Optional pause input present when PERM_CTRL_PAUSE_EN is defined.
`default_nettype none

interface perm_ctrl_if
    import perm_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                start;
`ifdef PERM_CTRL_PAUSE_EN
    logic                pause;
`endif
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ROUND_W-1:0]  round_idx;
    logic                busy;
    logic                done;

    modport master (
        output start,
`ifdef PERM_CTRL_PAUSE_EN
        output pause,
`endif
        input  rd_en, rd_addr, wr_en, wr_addr, round_idx, busy, done
    );

    modport slave (
        input  start,
`ifdef PERM_CTRL_PAUSE_EN
        input  pause,
`endif
        output rd_en, rd_addr, wr_en, wr_addr, round_idx, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/sweep_counter.sv
// sweep_counter: ADDR_W-bit address counter with clear, enable and carry-out.
`default_nettype none

module sweep_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              carry_o
);

    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    assign cnt_o   = cnt_q;
    assign carry_o = en_i & (&cnt_q);

endmodule

`default_nettype wire

// File: rtl/perm_ctrl.sv
// perm_ctrl: sequences ROUNDS read/write sweeps over a 2**ADDR_W permutation memory.
// Build option: PERM_CTRL_PAUSE_EN adds a pause input that freezes an active job.
`default_nettype none

module perm_ctrl
    import perm_ctrl_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic       clk,
    input  logic       reset,
    perm_ctrl_if.slave bus_if
);

    localparam logic [ROUND_W-1:0] c_LAST_ROUND = ROUND_W'(ROUNDS - 1);

    logic [1:0]         state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;

    logic               w_hold;
    logic               w_rd_en;
    logic               w_clr;
    logic               w_carry;
    logic [ADDR_W-1:0]  w_cnt;

`ifdef PERM_CTRL_PAUSE_EN
    assign w_hold = bus_if.pause & ((state_q == ST_SWEEP) | (state_q == ST_DRAIN));
`else
    assign w_hold = 1'b0;
`endif

    assign w_rd_en = (state_q == ST_SWEEP) & ~w_hold;
    assign w_clr   = (state_q == ST_IDLE) & bus_if.start;

    sweep_counter #(
        .ADDR_W (ADDR_W)
    ) u_sweep_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_clr),
        .en_i    (w_rd_en),
        .cnt_o   (w_cnt),
        .carry_o (w_carry)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    state_d = ST_SWEEP;
                    round_d = '0;
                end
            end
            ST_SWEEP: begin
                // carry already includes the enable, so a paused sweep never exits
                if (w_carry) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_hold) begin
                    if (round_q == c_LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SWEEP;
                        round_d = round_q + ROUND_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            round_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            // write pipeline holds its pending entry while paused
            if (!w_hold) begin
                wr_en_q   <= w_rd_en;
                wr_addr_q <= w_cnt;
            end
        end
    end

    assign bus_if.rd_en     = w_rd_en;
    assign bus_if.rd_addr   = w_cnt;
    assign bus_if.wr_en     = wr_en_q & ~w_hold;
    assign bus_if.wr_addr   = wr_addr_q;
    assign bus_if.round_idx = round_q;
    assign bus_if.busy      = (state_q != ST_IDLE);
    assign bus_if.done      = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_perm_ctrl.sv
// tb_perm_ctrl: vector table, corner-case sequences and a randomized run against a cycle-count model.
`default_nettype none

module tb_perm_ctrl;

    localparam int ROUNDS = 24;
    localparam int ADDR_W = 6;
    localparam int SWEEP  = 64;
    localparam int JOB    = ROUNDS * (SWEEP + 1);
    localparam int DONE_C = JOB + 1;

    typedef struct packed {
        logic       rd_en;
        logic [5:0] rd_addr;
        logic       wr_en;
        logic [5:0] wr_addr;
        logic [4:0] round_idx;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        int   cyc;
        bit   start;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_t, m_r;

    perm_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    perm_ctrl #(
        .ROUNDS (ROUNDS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(bit re, int ra, bit we, int wa, int rn, bit b, bit d);
        out_t o;
        o.rd_en     = re;
        o.rd_addr   = 6'(ra);
        o.wr_en     = we;
        o.wr_addr   = 6'(wa);
        o.round_idx = 5'(rn);
        o.busy      = b;
        o.done      = d;
        return o;
    endfunction

    // Expected outputs from job-relative cycle t (0 = idle) and idle round value r.
    function automatic out_t model_out(int t, int r);
        int p;
        if (t == 0)      return mk(0, 0, 0, 0, r, 0, 0);
        if (t > JOB)     return mk(0, 0, 0, 0, ROUNDS - 1, 1, 1);
        p = (t - 1) % (SWEEP + 1);
        if (p < SWEEP)   return mk(1, p, p != 0, (p == 0) ? 0 : p - 1, (t - 1) / (SWEEP + 1), 1, 0);
        return mk(0, 0, 1, SWEEP - 1, (t - 1) / (SWEEP + 1), 1, 0);
    endfunction

    task automatic model_step(input bit st);
        if (m_t == 0) begin
            if (st) m_t = 1;
        end else if (m_t == DONE_C) begin
            m_t = 0;
            m_r = ROUNDS - 1;
        end else begin
            m_t++;
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.rd_en     = bus.rd_en;
        o.rd_addr   = bus.rd_addr;
        o.wr_en     = bus.wr_en;
        o.wr_addr   = bus.wr_addr;
        o.round_idx = bus.round_idx;
        o.busy      = bus.busy;
        o.done      = bus.done;
        return o;
    endfunction

    task automatic check(input string nm, input out_t exp);
        out_t act;
        act = sample();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got rd=%0b/%0d wr=%0b/%0d rnd=%0d busy=%0b done=%0b, want rd=%0b/%0d wr=%0b/%0d rnd=%0d busy=%0b done=%0b",
                      nm, act.rd_en, act.rd_addr, act.wr_en, act.wr_addr, act.round_idx, act.busy, act.done,
                      exp.rd_en, exp.rd_addr, exp.wr_en, exp.wr_addr, exp.round_idx, exp.busy, exp.done);
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advance until done is seen or the cycle budget runs out; done_at = -1 on timeout.
    task automatic run_to_done(inout int c, output int done_at);
        done_at = -1;
        while (c < 4000) begin
            if (bus.done === 1'b1) begin
                done_at = c;
                return;
            end
            tick();
            c++;
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   k, done_n, done_at, busy_n, addr_err, rnd_err, c, d1, d2;

        reset     = 1'b1;
        bus.start = 1'b0;
`ifdef PERM_CTRL_PAUSE_EN
        bus.pause = 1'b0;
`endif

        tbl.push_back('{0,    1'b1, mk(0, 0,  0, 0,  0,  0, 0)});
        tbl.push_back('{1,    1'b0, mk(1, 0,  0, 0,  0,  1, 0)});
        tbl.push_back('{2,    1'b0, mk(1, 1,  1, 0,  0,  1, 0)});
        tbl.push_back('{30,   1'b1, mk(1, 29, 1, 28, 0,  1, 0)});
        tbl.push_back('{64,   1'b0, mk(1, 63, 1, 62, 0,  1, 0)});
        tbl.push_back('{65,   1'b0, mk(0, 0,  1, 63, 0,  1, 0)});
        tbl.push_back('{66,   1'b0, mk(1, 0,  0, 0,  1,  1, 0)});
        tbl.push_back('{67,   1'b0, mk(1, 1,  1, 0,  1,  1, 0)});
        tbl.push_back('{130,  1'b0, mk(0, 0,  1, 63, 1,  1, 0)});
        tbl.push_back('{131,  1'b0, mk(1, 0,  0, 0,  2,  1, 0)});
        tbl.push_back('{700,  1'b1, mk(1, 49, 1, 48, 10, 1, 0)});
        tbl.push_back('{1495, 1'b0, mk(0, 0,  1, 63, 22, 1, 0)});
        tbl.push_back('{1496, 1'b0, mk(1, 0,  0, 0,  23, 1, 0)});
        tbl.push_back('{1560, 1'b0, mk(0, 0,  1, 63, 23, 1, 0)});
        tbl.push_back('{1561, 1'b0, mk(0, 0,  0, 0,  23, 1, 1)});
        tbl.push_back('{1562, 1'b0, mk(0, 0,  0, 0,  23, 0, 0)});

        // Table-driven job from reset; start pulses at 30 and 700 must be ignored.
        reset_dut();
        k = 0; done_n = 0; done_at = -1; busy_n = 0; addr_err = 0; rnd_err = 0;
        for (int cy = 0; cy <= 1562; cy++) begin
            bus.start = 1'b0;
            if (k < tbl.size() && tbl[k].cyc == cy) begin
                check($sformatf("vec_c%0d", cy), tbl[k].exp);
                bus.start = tbl[k].start;
                k++;
            end
            if (bus.done === 1'b1) begin done_n++; done_at = cy; end
            if (bus.busy === 1'b1) busy_n++;
            if (cy >= 1 && cy <= 64 && (bus.rd_en !== 1'b1 || bus.rd_addr !== 6'(cy - 1))) addr_err++;
            if (cy == 65 && bus.rd_en !== 1'b0) addr_err++;
            if (cy >= 2 && cy <= 65 && (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'(cy - 2))) addr_err++;
            if (cy >= 1 && cy <= JOB && bus.round_idx !== 5'((cy - 1) / (SWEEP + 1))) rnd_err++;
            tick();
        end
        bus.start = 1'b0;
        check_int("done_cycle", done_at, DONE_C);
        check_int("done_pulses", done_n, 1);
        check_int("busy_cycles", busy_n, DONE_C);
        check_int("round0_addr_errs", addr_err, 0);
        check_int("round_seq_errs", rnd_err, 0);

        // Asynchronous reset at round 3, address 17, then a clean job.
        reset_dut();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cy = 1; cy < 213; cy++) tick();
        check("rst_pre", mk(1, 17, 1, 16, 3, 1, 0));
        #2 reset = 1'b1;
        #1 check("rst_async", mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", mk(0, 0, 0, 0, 0, 0, 0));
        end
        reset = 1'b0;
        tick();
        check("rst_idle", mk(0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        run_to_done(c, d1);
        check_int("rst_rejob_done", d1, DONE_C);

        // start held high: back-to-back jobs with one idle cycle between.
        reset_dut();
        bus.start = 1'b1;
        c = 0;
        run_to_done(c, d1);
        check_int("b2b_done1", d1, DONE_C);
        tick(); c++;
        check_int("b2b_idle_gap", int'(bus.busy), 0);
        tick(); c++;
        check("b2b_restart", mk(1, 0, 0, 0, 0, 1, 0));
        run_to_done(c, d2);
        bus.start = 1'b0;
        check_int("b2b_period", d2 - d1, DONE_C + 1);
        tick();
        tick();
        check("b2b_stop", mk(0, 0, 0, 0, ROUNDS - 1, 0, 0));

`ifdef PERM_CTRL_PAUSE_EN
        // Pause for 5 cycles at address 40: strobes off, addresses held, done 5 cycles late.
        reset_dut();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        while (c < 41) begin tick(); c++; end
        check("pause_pre", mk(1, 40, 1, 39, 0, 1, 0));
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("pause_hold%0d", i), mk(0, 40, 0, 39, 0, 1, 0));
            tick(); c++;
        end
        bus.pause = 1'b0;
        #1 check("pause_resume", mk(1, 40, 1, 39, 0, 1, 0));
        run_to_done(c, d1);
        check_int("pause_done", d1, DONE_C + 5);
`endif

        // Randomized starts and resets against the cycle-count model.
        reset_dut();
        m_t = 0;
        m_r = 0;
        for (int i = 0; i < 8000; i++) begin
            bit st, rs;
            st = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 2499) == 0);
            bus.start = st;
            if (rs) begin
                reset = 1'b1;
                #1 check("rand_async_rst", mk(0, 0, 0, 0, 0, 0, 0));
                m_t = 0;
                m_r = 0;
            end
            @(posedge clk);
            if (!rs) model_step(st);
            @(negedge clk);
            reset = 1'b0;
            check("rand", model_out(m_t, m_r));
        end
        bus.start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
